sm83_alu_core: RTL and testbench

Sequential 4-bit-datapath ALU core for the SM83 CPU. It computes 8-bit arithmetic and logic results in two nibble passes, low nibble first, then high nibble. It feeds the flags stage: a nibble carry after the low pass (half carry), then a full carry, zero and sign after the high pass. CPU control drives it with a start/done handshake and reads the result for register writeback.

---
 rtl/sm83_alu_core.sv | 139 +++++++++++++
 tb/tb_sm83_alu_core.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sm83_alu_core.sv
// sm83_alu_core: sequential nibble-serial ALU for the SM83 CPU.
// An 8-bit (WORD_SIZE) operation runs in two passes: low nibble, then high nibble.
// The low pass strobes hc_valid with the nibble carry/borrow on carry_to_flags.
// The high pass strobes done with the full result, carry, zero and sign.
//
// Ports:
//   clk, reset      clock (posedge), asynchronous active-high reset
//   start           begin an operation; only sampled in IDLE
//   op              0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 AND, 5 XOR, 6 OR, 7 CP
//   a_in, b_in      operands
//   cin             carry flag in; only ADC/SBC use it
//   busy            state != IDLE
//   hc_valid        one-cycle strobe: carry_to_flags holds the nibble carry
//   done            one-cycle strobe: result and flags valid
//   result          registered result
//   carry_to_flags  nibble carry (hc_valid), full carry (done), else 0
//   zero_out        result == 0
//   sign_out        result MSB
//   writeback       high with done unless op is CP
module sm83_alu_core #(
   parameter int unsigned WORD_SIZE = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [2:0]           op,
   input  logic [WORD_SIZE-1:0] a_in,
   input  logic [WORD_SIZE-1:0] b_in,
   input  logic                 cin,
   output logic                 busy,
   output logic                 hc_valid,
   output logic                 done,
   output logic [WORD_SIZE-1:0] result,
   output logic                 carry_to_flags,
   output logic                 zero_out,
   output logic                 sign_out,
   output logic                 writeback
);

   localparam int unsigned NW = WORD_SIZE / 2;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LO   = 2'd1;
   localparam logic [1:0] ST_HI   = 2'd2;

   localparam logic [2:0] OP_ADC = 3'd1;
   localparam logic [2:0] OP_SUB = 3'd2;
   localparam logic [2:0] OP_SBC = 3'd3;
   localparam logic [2:0] OP_AND = 3'd4;
   localparam logic [2:0] OP_XOR = 3'd5;
   localparam logic [2:0] OP_OR  = 3'd6;
   localparam logic [2:0] OP_CP  = 3'd7;

   logic [1:0]           state;
   logic [WORD_SIZE-1:0] a_q, b_q;
   logic [2:0]           op_q;
   logic                 c_q;     // effective carry/borrow in
   logic                 nib_c;   // raw adder carry-out of the low pass

   logic          is_sub, is_arith, chain_in, co, rep;
   logic [NW-1:0] nib_a, nib_b, b_eff, logic_res, nib_res;
   logic [NW:0]   sum;

   always_comb begin
      is_sub   = (op_q == OP_SUB) || (op_q == OP_SBC) || (op_q == OP_CP);
      is_arith = !((op_q == OP_AND) || (op_q == OP_XOR) || (op_q == OP_OR));
      nib_a    = (state == ST_HI) ? a_q[WORD_SIZE-1:NW] : a_q[NW-1:0];
      nib_b    = (state == ST_HI) ? b_q[WORD_SIZE-1:NW] : b_q[NW-1:0];
      // Subtraction is a + ~b + ~borrow; the chain between nibbles carries the raw carry-out.
      b_eff    = is_sub ? ~nib_b : nib_b;
      chain_in = (state == ST_HI) ? nib_c : (is_sub ? ~c_q : c_q);
      sum      = {1'b0, nib_a} + {1'b0, b_eff} + {{NW{1'b0}}, chain_in};
      co       = sum[NW];
      // Borrow is reported as the inverted carry-out; logic ops report no carry.
      rep      = is_arith & (co ^ is_sub);
      case (op_q)
         OP_AND:  logic_res = nib_a & nib_b;
         OP_XOR:  logic_res = nib_a ^ nib_b;
         OP_OR:   logic_res = nib_a | nib_b;
         default: logic_res = '0;
      endcase
      nib_res = is_arith ? sum[NW-1:0] : logic_res;
   end

   assign busy = (state != ST_IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= ST_IDLE;
         a_q            <= '0;
         b_q            <= '0;
         op_q           <= '0;
         c_q            <= 1'b0;
         nib_c          <= 1'b0;
         hc_valid       <= 1'b0;
         done           <= 1'b0;
         result         <= '0;
         carry_to_flags <= 1'b0;
         zero_out       <= 1'b0;
         sign_out       <= 1'b0;
         writeback      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               hc_valid       <= 1'b0;
               done           <= 1'b0;
               carry_to_flags <= 1'b0;
               writeback      <= 1'b0;
               if (start) begin
                  a_q   <= a_in;
                  b_q   <= b_in;
                  op_q  <= op;
                  c_q   <= ((op == OP_ADC) || (op == OP_SBC)) ? cin : 1'b0;
                  state <= ST_LO;
               end
            end
            ST_LO: begin
               result[NW-1:0] <= nib_res;
               nib_c          <= co;
               carry_to_flags <= rep;
               hc_valid       <= 1'b1;
               state          <= ST_HI;
            end
            ST_HI: begin
               result[WORD_SIZE-1:NW] <= nib_res;
               carry_to_flags         <= rep;
               zero_out               <= ({nib_res, result[NW-1:0]} == '0);
               sign_out               <= nib_res[NW-1];
               hc_valid               <= 1'b0;
               done                   <= 1'b1;
               writeback              <= (op_q != OP_CP);
               state                  <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sm83_alu_core.sv
// Directed bench for sm83_alu_core with a scoreboard of expected results.
module tb_sm83_alu_core;

   logic       clk = 1'b0;
   logic       reset, start, cin;
   logic [2:0] op;
   logic [7:0] a_in, b_in;
   logic       busy, hc_valid, done, carry_to_flags, zero_out, sign_out, writeback;
   logic [7:0] result;

   typedef struct {
      logic [7:0] res;
      logic       hc;
      logic       c;
      logic       z;
      logic       s;
      logic       wb;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   sm83_alu_core #(.WORD_SIZE(8)) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .op             (op),
      .a_in           (a_in),
      .b_in           (b_in),
      .cin            (cin),
      .busy           (busy),
      .hc_valid       (hc_valid),
      .done           (done),
      .result         (result),
      .carry_to_flags (carry_to_flags),
      .zero_out       (zero_out),
      .sign_out       (sign_out),
      .writeback      (writeback)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic exp_t model(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                                  input logic ci);
      exp_t e;
      int   c, ia, ib, r;
      c  = (o == 3'd1 || o == 3'd3) ? int'(ci) : 0;
      ia = int'(a);
      ib = int'(b);
      e.hc = 1'b0;
      e.c  = 1'b0;
      case (o)
         3'd0, 3'd1: begin
            r    = ia + ib + c;
            e.hc = ((ia % 16) + (ib % 16) + c) > 15;
            e.c  = r > 255;
         end
         3'd2, 3'd3, 3'd7: begin
            r    = ia - ib - c;
            e.hc = (ia % 16) < ((ib % 16) + c);
            e.c  = ia < (ib + c);
         end
         3'd4:    r = int'(a & b);
         3'd5:    r = int'(a ^ b);
         default: r = int'(a | b);
      endcase
      e.res = r[7:0];
      e.z   = (e.res == 8'h00);
      e.s   = e.res[7];
      e.wb  = (o != 3'd7);
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                        input logic ci);
      op    = o;
      a_in  = a;
      b_in  = b;
      cin   = ci;
      start = 1'b1;
      exp_q.push_back(model(o, a, b, ci));
   endtask

   // Issue one op and advance to its done cycle.
   task automatic run_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                         input logic ci);
      drive(o, a, b, ci);
      tick();
      start = 1'b0;
      tick();
      tick();
      chk("done_latency", done, 1);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_hc_valid"}, hc_valid, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_result"}, result, 0);
      chk({tag, "_carry"}, carry_to_flags, 0);
      chk({tag, "_zero"}, zero_out, 0);
      chk({tag, "_sign"}, sign_out, 0);
      chk({tag, "_writeback"}, writeback, 0);
   endtask

   // Scoreboard monitor, sampled away from the active edge.
   always @(negedge clk) begin
      exp_t e;
      if (reset === 1'b0) begin
         if (hc_valid) begin
            chk("strobes_exclusive", done, 0);
            if (exp_q.size() == 0) chk("hc_unexpected", hc_valid, 0);
            else chk("half_carry", carry_to_flags, exp_q[0].hc);
         end else if (done) begin
            if (exp_q.size() == 0) begin
               chk("done_unexpected", done, 0);
            end else begin
               e = exp_q.pop_front();
               chk("result", result, e.res);
               chk("carry", carry_to_flags, e.c);
               chk("zero", zero_out, e.z);
               chk("sign", sign_out, e.s);
               chk("writeback", writeback, e.wb);
               chk("busy_in_done", busy, 0);
            end
         end else begin
            chk("carry_idle", carry_to_flags, 0);
            chk("writeback_idle", writeback, 0);
         end
      end
   end

   initial begin
      reset = 1'b1;
      start = 1'b0;
      op    = 3'd0;
      a_in  = 8'h00;
      b_in  = 8'h00;
      cin   = 1'b0;
      tick();
      tick();
      chk_all_zero("reset");
      reset = 1'b0;
      tick();

      // Arithmetic and logic; cin must be ignored by ADD.
      run_op(3'd0, 8'h3A, 8'hC6, 1'b1);
      run_op(3'd2, 8'h10, 8'h01, 1'b0);
      run_op(3'd7, 8'h10, 8'h01, 1'b0);
      run_op(3'd3, 8'h00, 8'h00, 1'b1);
      run_op(3'd1, 8'h0F, 8'h00, 1'b1);
      run_op(3'd4, 8'hF0, 8'h0F, 1'b0);
      run_op(3'd5, 8'hFF, 8'h0F, 1'b0);
      run_op(3'd6, 8'h12, 8'h40, 1'b1);
      run_op(3'd7, 8'h3E, 8'h3E, 1'b1);
      run_op(3'd1, 8'h88, 8'h77, 1'b1);
      tick();

      // Handshake: start held into LO is ignored; new start in the done cycle.
      drive(3'd0, 8'h22, 8'h11, 1'b0);
      tick();
      chk("hs_busy_lo", busy, 1);
      chk("hs_hc_not_yet", hc_valid, 0);
      op   = 3'd5;
      a_in = 8'h99;
      b_in = 8'h99;
      tick();
      chk("hs_hc_valid", hc_valid, 1);
      chk("hs_no_done_yet", done, 0);
      start = 1'b0;
      tick();
      chk("hs_done", done, 1);
      chk("hs_hc_dropped", hc_valid, 0);
      chk("hs_result_first", result, 8'h33);
      drive(3'd0, 8'h05, 8'h07, 1'b0);
      tick();
      start = 1'b0;
      chk("hs_busy_second", busy, 1);
      chk("hs_result_held", result[7:4], 4'h3);
      tick();
      tick();
      chk("hs_done_second", done, 1);
      chk("hs_result_second", result, 8'h0C);
      tick();

      // Asynchronous reset in the HI cycle aborts the operation.
      drive(3'd0, 8'h55, 8'h55, 1'b0);
      tick();
      start = 1'b0;
      tick();
      chk("abort_in_hi", hc_valid, 1);
      #2;
      reset = 1'b1;
      #1;
      chk_all_zero("abort");
      exp_q.delete();
      tick();
      chk("abort_no_done", done, 0);
      reset = 1'b0;
      tick();
      chk("abort_still_idle", busy, 0);
      run_op(3'd0, 8'h01, 8'h01, 1'b0);
      chk("post_reset_result", result, 8'h02);
      tick();

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) tick();
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
